keypad_emulator: RTL and testbench

- Drives the far end of the 4x4 matrix-keypad interface that the stopwatch/calculator scanner uses.
- Watches the scanner's active-low column strobes (colunas) and pulls the matching active-low row line (linhas) low while a virtual key is closed.
- Press/release events arrive on a valid/ready command port, with programmable hold time and contact bounce.
- Used as the keypad model in system benches and as a scripted-input source for on-board self-test.

---
 rtl/keypad_pkg.sv | 53 +++++
 rtl/keypad_bounce_gen.sv | 56 +++++
 rtl/keypad_emulator.sv | 116 +++++++++++
 tb/tb_keypad_emulator.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, key-to-matrix mapping and FSM states for the keypad emulator
package keypad_pkg;
    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS_BOUNCE,
        S_HOLD,
        S_RELEASE_BOUNCE,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    function automatic key_pos_t key_pos(input logic [3:0] key);
        case (key)
            KEY_1:    return {2'd0, 2'd0};
            KEY_2:    return {2'd0, 2'd1};
            KEY_3:    return {2'd0, 2'd2};
            KEY_A:    return {2'd0, 2'd3};
            KEY_4:    return {2'd1, 2'd0};
            KEY_5:    return {2'd1, 2'd1};
            KEY_6:    return {2'd1, 2'd2};
            KEY_B:    return {2'd1, 2'd3};
            KEY_7:    return {2'd2, 2'd0};
            KEY_8:    return {2'd2, 2'd1};
            KEY_9:    return {2'd2, 2'd2};
            KEY_C:    return {2'd2, 2'd3};
            KEY_STAR: return {2'd3, 2'd0};
            KEY_0:    return {2'd3, 2'd1};
            KEY_HASH: return {2'd3, 2'd2};
            KEY_D:    return {2'd3, 2'd3};
        endcase
    endfunction
endpackage

// File: rtl/keypad_bounce_gen.sv
// keypad_bounce_gen: contact-bounce waveform generator (pairs of half-periods from a start level)
//   clock/reset : system clock, sync active-high reset
//   start_i     : load a new phase (level_i, pairs_i); pairs_i must be nonzero
//   lvl_o       : current bounce level
//   last_o      : high during the final cycle of the phase
module keypad_bounce_gen
    import keypad_pkg::*;
#(
    parameter int PH_W        = 11,
    parameter int HALF_PERIOD = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic       level_i,
    input  logic [3:0] pairs_i,
    output logic       lvl_o,
    output logic       last_o
);
    logic [PH_W-1:0] ph_q, ph_d;
    logic [4:0]      tog_q, tog_d;
    logic            lvl_q, lvl_d;

    // tog_q counts remaining level flips; the counters saturate at zero
    always_comb begin
        ph_d  = ph_q;
        tog_d = tog_q;
        lvl_d = lvl_q;
        if (start_i) begin
            ph_d  = PH_W'(HALF_PERIOD - 1);
            tog_d = {pairs_i, 1'b0} - 5'd1;
            lvl_d = level_i;
        end else if (ph_q != '0) begin
            ph_d = ph_q - 1'b1;
        end else if (tog_q != '0) begin
            ph_d  = PH_W'(HALF_PERIOD - 1);
            tog_d = tog_q - 5'd1;
            lvl_d = ~lvl_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ph_q  <= '0;
            tog_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            tog_q <= tog_d;
            lvl_q <= lvl_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign last_o = (ph_q == '0) && (tog_q == '0);
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: scripted 4x4 matrix-keypad model driven by press/release commands
//   clock/reset          : system clock, sync active-high reset
//   colunas / linhas     : active-low column strobes in, active-low row returns out (registered)
//   cmd_valid/cmd_ready  : command handshake; cmd_key, cmd_hold, cmd_bounces latched on accept
//   contato, busy, done  : virtual contact state, command in progress, completion pulse
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_PERIOD = 1000,
    parameter int GAP_CYCLES    = 2000,
    parameter int HOLD_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        colunas,
    output logic [3:0]        linhas,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        cmd_bounces,
    output logic              contato,
    output logic              busy,
    output logic              done
);
    localparam int PH_W = $clog2((BOUNCE_PERIOD > GAP_CYCLES ? BOUNCE_PERIOD : GAP_CYCLES) + 1);

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
    logic [3:0]        key_q, key_d, bnc_q, bnc_d, linhas_q, linhas_d;
    logic              bg_start, bg_level, bg_lvl, bg_last;
    key_pos_t          pos;

    // a hold of 0 still closes the contact for one cycle
    function automatic logic [HOLD_W-1:0] hold_m1(input logic [HOLD_W-1:0] h);
        return (h == '0) ? '0 : h - 1'b1;
    endfunction

    keypad_bounce_gen #(.PH_W(PH_W), .HALF_PERIOD(BOUNCE_PERIOD)) u_bounce (
        .clock   (clock),
        .reset   (reset),
        .start_i (bg_start),
        .level_i (bg_level),
        .pairs_i ((state_q == S_IDLE) ? cmd_bounces : bnc_q),
        .lvl_o   (bg_lvl),
        .last_o  (bg_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        key_d    = key_q;
        hold_d   = hold_q;
        bnc_d    = bnc_q;
        bg_start = 1'b0;
        bg_level = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) begin
                key_d    = cmd_key;
                hold_d   = cmd_hold;
                bnc_d    = cmd_bounces;
                cnt_d    = hold_m1(cmd_hold);
                bg_start = cmd_bounces != 4'd0;
                bg_level = 1'b1;
                state_d  = (cmd_bounces == 4'd0) ? S_HOLD : S_PRESS_BOUNCE;
            end
            S_PRESS_BOUNCE: if (bg_last) begin
                cnt_d   = hold_m1(hold_q);
                state_d = S_HOLD;
            end
            S_HOLD: if (cnt_q == '0) begin
                cnt_d    = HOLD_W'(GAP_CYCLES - 1);
                bg_start = bnc_q != 4'd0;
                state_d  = (bnc_q == 4'd0) ? S_GAP : S_RELEASE_BOUNCE;
            end
            S_RELEASE_BOUNCE: if (bg_last) begin
                cnt_d   = HOLD_W'(GAP_CYCLES - 1);
                state_d = S_GAP;
            end
            S_GAP: if (cnt_q == '0) begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign contato = (state_q == S_HOLD) ||
                     (((state_q == S_PRESS_BOUNCE) || (state_q == S_RELEASE_BOUNCE)) && bg_lvl);
    assign pos      = key_pos(key_q);
    // only the key's own column matters; other low columns are ignored (wired-AND)
    assign linhas_d = (contato && !colunas[pos.col]) ? ~(4'b0001 << pos.row) : 4'b1111;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hold_q   <= '0;
            key_q    <= 4'd0;
            bnc_q    <= 4'd0;
            linhas_q <= 4'b1111;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            key_q    <= key_d;
            bnc_q    <= bnc_d;
            linhas_q <= linhas_d;
        end
    end

    assign linhas    = linhas_q;
    assign cmd_ready = state_q == S_IDLE;
    assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed self-checking bench for keypad_emulator (BOUNCE_PERIOD=4, GAP_CYCLES=8)
module tb_keypad_emulator;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  colunas = 4'b1111;
    logic [3:0]  linhas;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_key = 4'd0;
    logic [31:0] cmd_hold = 32'd0;
    logic [3:0]  cmd_bounces = 4'd0;
    logic        contato, busy, done;
    int          tests = 0;
    int          fails = 0;

    keypad_emulator #(.BOUNCE_PERIOD(4), .GAP_CYCLES(8), .HOLD_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .colunas     (colunas),
        .linhas      (linhas),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_key     (cmd_key),
        .cmd_hold    (cmd_hold),
        .cmd_bounces (cmd_bounces),
        .contato     (contato),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic issue(input logic [3:0] key, input logic [31:0] hold, input logic [3:0] bnc);
        cmd_valid   = 1'b1;
        cmd_key     = key;
        cmd_hold    = hold;
        cmd_bounces = bnc;
    endtask

    logic [3:0]  pat [4];
    logic [46:0] c_vec;
    logic        exp_c, prev_c;

    initial begin
        pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_linhas", linhas, 4'b1111);
        chk("rst_contato", contato, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);

        // clean press of key 5, hold 10
        issue(4'd5, 32'd10, 4'd0);
        colunas = 4'b1101;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            chk("t1_contato", contato, (k <= 10) ? 1 : 0);
            chk("t1_linhas", linhas, (k >= 2 && k <= 11) ? 4'b1101 : 4'b1111);
            chk("t1_done", done, (k == 18) ? 1 : 0);
            chk("t1_ready", cmd_ready, (k >= 19) ? 1 : 0);
            chk("t1_busy", busy, (k <= 18) ? 1 : 0);
        end

        // key 5 with rotating column strobes, hold 12
        issue(4'd5, 32'd12, 4'd0);
        colunas = pat[0];
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            chk("t2_linhas", linhas, (k >= 7 && k <= 9) ? 4'b1101 : 4'b1111);
            chk("t2_done", done, (k == 20) ? 1 : 0);
            colunas = pat[2'((k / 3) % 4)];
        end

        // key C with two bounce pairs, hold 6
        issue(4'd12, 32'd6, 4'd2);
        colunas = 4'b0111;
        c_vec  = {16'b1111000011110000, 6'b111111, 16'b0000111100001111, 8'b00000000, 1'b0};
        prev_c = 1'b0;
        for (int k = 1; k <= 47; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            exp_c = c_vec[47 - k];
            chk("t3_contato", contato, exp_c);
            chk("t3_linhas", linhas, prev_c ? 4'b1011 : 4'b1111);
            chk("t3_done", done, (k == 46) ? 1 : 0);
            prev_c = exp_c;
        end

        // '#' then 3 back-to-back with cmd_valid held high
        issue(4'd15, 32'd2, 4'd0);
        colunas = 4'b1011;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 1) cmd_key = 4'd3;
            chk("t4_linhas", linhas, (k == 2 || k == 3) ? 4'b0111 :
                                     (k == 13 || k == 14) ? 4'b1110 : 4'b1111);
            chk("t4_done", done, (k == 10 || k == 21) ? 1 : 0);
            chk("t4_ready", cmd_ready, (k == 11 || k >= 22) ? 1 : 0);
            if (k == 12) cmd_valid = 1'b0;
        end

        // reset in the middle of HOLD for key 1
        issue(4'd1, 32'd20, 4'd0);
        colunas = 4'b1110;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
        end
        chk("t5_hold_linhas", linhas, 4'b1110);
        chk("t5_hold_contato", contato, 1);
        reset = 1'b1;
        tick();
        chk("t5_rst_linhas", linhas, 4'b1111);
        chk("t5_rst_contato", contato, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("t5_ready", cmd_ready, 1);
            chk("t5_done", done, 0);
            chk("t5_linhas", linhas, 4'b1111);
        end

        // hold of zero gives a single closed cycle
        issue(4'd1, 32'd0, 4'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) cmd_valid = 1'b0;
            chk("t6_contato", contato, (k == 1) ? 1 : 0);
            chk("t6_linhas", linhas, (k == 2) ? 4'b1110 : 4'b1111);
            chk("t6_done", done, (k == 9) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
